// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the pipeline hazard unit: RV32 opcodes, forward selects,
// and the per-stage scoreboard entry tracked for X, M and W.
package hazard_unit_pkg;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       is_load;
    } sb_entry_t;

    // A load still in X has no result yet, so it is never a MEM-stage source.
    function automatic logic [1:0] fwd_select(
        input logic       used,
        input logic [4:0] rs,
        input sb_entry_t  x,
        input sb_entry_t  m
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (used && rs != 5'd0) begin
            if (x.valid && x.wr && !x.is_load && x.rd == rs) begin
                sel = FWD_MEM;
            end else if (m.valid && m.wr && m.rd == rs) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    function automatic logic hits_load(
        input logic       used,
        input logic [4:0] rs,
        input sb_entry_t  x
    );
        return used && rs != 5'd0 && x.valid && x.wr && x.is_load && x.rd == rs;
    endfunction

endpackage

// File: rtl/hazard_unit_decode.sv
// Purely combinational field extraction for the instruction in decode:
// register indices plus which of them the opcode actually reads or writes.
module hazard_decode
    import hazard_unit_pkg::*;
(
    input  logic [31:0] inst,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        writes_rd,
    output logic        is_load
);

    logic [6:0] opcode;
    logic       unused_bits;

    assign opcode      = inst[6:0];
    assign rs1         = inst[19:15];
    assign rs2         = inst[24:20];
    assign rd          = inst[11:7];
    assign unused_bits = ^{inst[31:25], inst[14:12]};

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        unique case (opcode)
            OP_OP:     begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
            OP_IMM:    begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
            OP_LOAD:   begin uses_rs1 = 1'b1; writes_rd = 1'b1; is_load = 1'b1; end
            OP_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_JALR:   begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
            OP_LUI,
            OP_AUIPC,
            OP_JAL:    writes_rd = 1'b1;
            default:   ;
        endcase
        // x0 is hardwired zero: writing it creates no dependency.
        if (rd == 5'd0) begin
            writes_rd = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: freeze on data-memory wait, flush on redirect,
// one-cycle load-use stall, and registered operand-forward selects for X.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] inst_d,
    input  logic        inst_valid_d,
    input  logic        branch_taken_x,
    input  logic        jump_x,
    input  logic        dmem_busy,
    output logic        stall_fd,
    output logic        flush_d,
    output logic        bubble_x,
    output logic        freeze,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rd_d;
    logic       uses_rs1_d;
    logic       uses_rs2_d;
    logic       writes_rd_d;
    logic       is_load_d;

    sb_entry_t  sb_x;
    sb_entry_t  sb_m;
    sb_entry_t  sb_w;
    sb_entry_t  next_x;
    logic [1:0] next_fwd_a;
    logic [1:0] next_fwd_b;

    logic       redirect;
    logic       load_use;
    logic       unused_sb_w;

    hazard_decode u_decode (
        .inst      (inst_d),
        .rs1       (rs1_d),
        .rs2       (rs2_d),
        .rd        (rd_d),
        .uses_rs1  (uses_rs1_d),
        .uses_rs2  (uses_rs2_d),
        .writes_rd (writes_rd_d),
        .is_load   (is_load_d)
    );

    assign redirect = (branch_taken_x | jump_x) & sb_x.valid;
    assign load_use = inst_valid_d &
                      (hits_load(uses_rs1_d, rs1_d, sb_x) |
                       hits_load(uses_rs2_d, rs2_d, sb_x));

    // W is the tail of the shift chain; it has no consumer inside this block.
    assign unused_sb_w = ^sb_w;

    always_comb begin
        stall_fd = 1'b0;
        flush_d  = 1'b0;
        bubble_x = 1'b0;
        freeze   = 1'b0;
        if (reset) begin
            flush_d  = 1'b1;
            bubble_x = 1'b1;
        end else if (dmem_busy) begin
            freeze = 1'b1;
        end else if (redirect) begin
            flush_d  = 1'b1;
            bubble_x = 1'b1;
        end else if (load_use) begin
            stall_fd = 1'b1;
            bubble_x = 1'b1;
        end
    end

    always_comb begin
        next_x = '0;
        if (!bubble_x) begin
            next_x.valid   = inst_valid_d;
            next_x.rd      = rd_d;
            next_x.wr      = writes_rd_d & inst_valid_d;
            next_x.is_load = is_load_d & inst_valid_d;
        end
    end

    always_comb begin
        next_fwd_a = FWD_RF;
        next_fwd_b = FWD_RF;
        if (!bubble_x && inst_valid_d) begin
            next_fwd_a = fwd_select(uses_rs1_d, rs1_d, sb_x, sb_m);
            next_fwd_b = fwd_select(uses_rs2_d, rs2_d, sb_x, sb_m);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sb_x      <= '0;
            sb_m      <= '0;
            sb_w      <= '0;
            fwd_a     <= FWD_RF;
            fwd_b     <= FWD_RF;
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else if (!freeze) begin
            sb_w  <= sb_m;
            sb_m  <= sb_x;
            sb_x  <= next_x;
            fwd_a <= next_fwd_a;
            fwd_b <= next_fwd_b;
            if (redirect) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
            if (load_use && !redirect) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scripted pipeline sequences against hazard_unit; each cycle's expected
// control/forward/counter picture is queued at drive time and checked mid-cycle.
module tb_hazard_unit;

    localparam int W = 72;
    localparam logic [3:0] C_NONE  = 4'b0000;
    localparam logic [3:0] C_STALL = 4'b1010;
    localparam logic [3:0] C_FLUSH = 4'b0110;
    localparam logic [3:0] C_FRZ   = 4'b0001;
    localparam logic [3:0] C_RST   = 4'b0110;

    logic        clock;
    logic        reset;
    logic [31:0] inst_d;
    logic        inst_valid_d;
    logic        branch_taken_x;
    logic        jump_x;
    logic        dmem_busy;
    logic        stall_fd;
    logic        flush_d;
    logic        bubble_x;
    logic        freeze;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_checks;
    int           n_fail;

    hazard_unit dut (
        .clock          (clock),
        .reset          (reset),
        .inst_d         (inst_d),
        .inst_valid_d   (inst_valid_d),
        .branch_taken_x (branch_taken_x),
        .jump_x         (jump_x),
        .dmem_busy      (dmem_busy),
        .stall_fd       (stall_fd),
        .flush_d        (flush_d),
        .bubble_x       (bubble_x),
        .freeze         (freeze),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // instruction builders
    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [6:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, op};
    endfunction

    function automatic logic [31:0] jal_to(input logic [4:0] rd);
        return {20'd0, rd, 7'b1101111};
    endfunction

    function automatic logic [W-1:0] mk(input logic [3:0] ctl, input logic [1:0] fa,
                                        input logic [1:0] fb, input logic [31:0] sc,
                                        input logic [31:0] fc);
        return {ctl, fa, fb, sc, fc};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: pop the oldest expectation and compare against the live outputs
    task automatic sample_and_compare();
        logic [W-1:0] e;
        string        t;
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_eq({t, "/ctl"}, {28'd0, stall_fd, flush_d, bubble_x, freeze}, {28'd0, e[71:68]});
        check_eq({t, "/fwd_a"}, {30'd0, fwd_a}, {30'd0, e[67:66]});
        check_eq({t, "/fwd_b"}, {30'd0, fwd_b}, {30'd0, e[65:64]});
        check_eq({t, "/stall_cnt"}, stall_cnt, e[63:32]);
        check_eq({t, "/flush_cnt"}, flush_cnt, e[31:0]);
    endtask

    // driver: apply one cycle of inputs after the falling edge, queue the expectation
    task automatic drive_step(input string tag, input logic [31:0] inst, input logic v,
                              input logic br, input logic jmp, input logic busy,
                              input logic rst, input logic [W-1:0] exp);
        @(negedge clock);
        inst_d         = inst;
        inst_valid_d   = v;
        branch_taken_x = br;
        jump_x         = jmp;
        dmem_busy      = busy;
        reset          = rst;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        sample_and_compare();
    endtask

    initial begin
        logic [31:0] lw_x5;
        logic [31:0] add_x6;
        logic [4:0]  rdb;

        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b1;
        inst_d         = 32'd0;
        inst_valid_d   = 1'b0;
        branch_taken_x = 1'b0;
        jump_x         = 1'b0;
        dmem_busy      = 1'b0;
        repeat (2) @(posedge clock);

        lw_x5  = i_type(7'b0000011, 5'd5, 5'd1, 12'd0);
        add_x6 = r_type(7'd0, 5'd6, 5'd5, 5'd2);
        rdb    = 5'($urandom_range(1, 31));

        drive_step("reset",      32'd0, 0, 0, 0, 0, 1, mk(C_RST, 2'd0, 2'd0, 0, 0));

        // load followed by dependent add
        drive_step("lu_lw",      lw_x5,  1, 0, 0, 0, 0, mk(C_NONE,  2'd0, 2'd0, 0, 0));
        drive_step("lu_stall",   add_x6, 1, 0, 0, 0, 0, mk(C_STALL, 2'd0, 2'd0, 0, 0));
        drive_step("lu_retry",   add_x6, 1, 0, 0, 0, 0, mk(C_NONE,  2'd0, 2'd0, 1, 0));
        drive_step("lu_exec",    32'd0,  0, 0, 0, 0, 0, mk(C_NONE,  2'd2, 2'd0, 1, 0));

        // ALU result forwarded from MEM to both operands
        drive_step("alu_prod",   r_type(7'd0, rdb, 5'd1, 5'd2), 1, 0, 0, 0, 0,
                   mk(C_NONE, 2'd0, 2'd0, 1, 0));
        drive_step("alu_cons",   r_type(7'b0100000, 5'd7, rdb, rdb), 1, 0, 0, 0, 0,
                   mk(C_NONE, 2'd0, 2'd0, 1, 0));
        drive_step("alu_exec",   32'd0,  0, 0, 0, 0, 0, mk(C_NONE,  2'd1, 2'd1, 1, 0));

        // redirect wins over a simultaneous load-use hazard
        drive_step("rd_lw",      lw_x5,  1, 0, 0, 0, 0, mk(C_NONE,  2'd0, 2'd0, 1, 0));
        drive_step("rd_flush",   add_x6, 1, 1, 0, 0, 0, mk(C_FLUSH, 2'd0, 2'd0, 1, 0));
        drive_step("rd_x_inval", 32'd0,  0, 1, 0, 0, 0, mk(C_NONE,  2'd0, 2'd0, 1, 1));

        // memory wait during a load-use hazard, then the stall
        drive_step("fz_lw",      lw_x5,  1, 0, 0, 0, 0, mk(C_NONE,  2'd0, 2'd0, 1, 1));
        for (int i = 0; i < 3; i++) begin
            drive_step("fz_hold", add_x6, 1, 0, 0, 1, 0, mk(C_FRZ, 2'd0, 2'd0, 1, 1));
        end
        drive_step("fz_stall",   add_x6, 1, 0, 0, 0, 0, mk(C_STALL, 2'd0, 2'd0, 1, 1));
        drive_step("fz_retry",   add_x6, 1, 0, 0, 0, 0, mk(C_NONE,  2'd0, 2'd0, 2, 1));
        drive_step("fz_over_br", 32'd0,  0, 1, 0, 1, 0, mk(C_FRZ,   2'd2, 2'd0, 2, 1));
        drive_step("fz_kept",    32'd0,  0, 0, 0, 0, 0, mk(C_NONE,  2'd2, 2'd0, 2, 1));

        // x0 never forwards or stalls
        drive_step("x0_addi",    i_type(7'b0010011, 5'd0, 5'd0, 12'd1), 1, 0, 0, 0, 0,
                   mk(C_NONE, 2'd0, 2'd0, 2, 1));
        drive_step("x0_add",     r_type(7'd0, 5'd3, 5'd0, 5'd0), 1, 0, 0, 0, 0,
                   mk(C_NONE, 2'd0, 2'd0, 2, 1));
        drive_step("x0_exec",    32'd0,  0, 0, 0, 0, 0, mk(C_NONE,  2'd0, 2'd0, 2, 1));

        // unconditional jump redirect
        drive_step("jmp_jal",    jal_to(5'd1), 1, 0, 0, 0, 0, mk(C_NONE, 2'd0, 2'd0, 2, 1));
        drive_step("jmp_flush",  r_type(7'd0, 5'd6, 5'd1, 5'd2), 1, 0, 1, 0, 0,
                   mk(C_FLUSH, 2'd0, 2'd0, 2, 1));

        // reset lands on a load-use stall cycle
        drive_step("rs_lw",      lw_x5,  1, 0, 0, 0, 0, mk(C_NONE,  2'd0, 2'd0, 2, 2));
        drive_step("rs_assert",  add_x6, 1, 0, 0, 0, 1, mk(C_RST,   2'd2, 2'd0, 2, 2));
        drive_step("rs_release", add_x6, 1, 0, 0, 0, 0, mk(C_NONE,  2'd0, 2'd0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
